// File: rtl/fe_pkg.sv
// Shared constants for the fetch front end: default widths, reset PC,
// the halt sentinel word and the decode opcode map.
package fe_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam logic [ADDR_WIDTH-1:0]  RESET_PC  = '0;
  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = '0;
  localparam int unsigned PC_STEP     = 4;

  // Major opcodes consumed by the decode/control stage downstream.
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with flush; head entry is read combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignment so all of them update together at the edge.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count gates visibility, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(push && full && !pop));
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: sequential PC generation, 1-cycle imem reads, response
// buffering to decode, redirect/flush and halt on the all-zero word.
module fetch_buffer import fe_pkg::*; #(
  parameter int unsigned INSTR_WIDTH = fe_pkg::INSTR_WIDTH,
  parameter int unsigned ADDR_WIDTH  = fe_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(fe_pkg::RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INSTR_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0]  dec_pc,
  output logic                   fetch_halted
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = INSTR_WIDTH + ADDR_WIDTH;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic                  inflight_q, inflight_d, kill_q, kill_d;
  logic                  active_q, active_d;

  logic [CNT_W-1:0]      count;
  logic [ENT_W-1:0]      head;
  logic                  resp_accept, halt_hit, push, pop;

  // active_q keeps imem_req low until the first edge after reset release.
  assign imem_req  = active_q && (state_q == ST_RUN) && !redirect_valid &&
                     ((32'(count) + 32'(inflight_q)) < DEPTH);
  assign imem_addr = pc_q;

  assign resp_accept = inflight_q && !kill_q && !redirect_valid;
  assign halt_hit    = resp_accept && (imem_rdata == INSTR_WIDTH'(HALT_WORD));
  assign push        = resp_accept && !halt_hit;
  assign pop         = dec_valid && dec_ready && !redirect_valid;

  always_comb begin
    active_d   = 1'b1;
    state_d    = state_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = imem_req;
    kill_d     = 1'b0;
    if (imem_req) begin
      pc_d      = pc_q + ADDR_WIDTH'(PC_STEP);
      resp_pc_d = pc_q;
    end
    // A request issued in the halt cycle returns after fetching has stopped.
    if (halt_hit) begin
      state_d = ST_HALTED;
      kill_d  = imem_req;
    end
    if (redirect_valid) begin
      state_d = ST_RUN;
      pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      kill_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      active_q   <= active_d;
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  instr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({imem_rdata, resp_pc_q}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_data (head)
  );

  assign dec_valid    = (count != '0);
  assign dec_instr    = dec_valid ? head[ENT_W-1:ADDR_WIDTH] : '0;
  assign dec_pc       = dec_valid ? head[ADDR_WIDTH-1:0]     : '0;
  assign fetch_halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: streaming, backpressure, redirect,
// halt, reset mid-operation, and PC wrap on an 8-bit-address instance.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc;
  logic        fetch_halted;

  logic        b_imem_req;
  logic [7:0]  b_imem_addr;
  logic [31:0] b_imem_rdata;
  logic        b_redirect_valid;
  logic [7:0]  b_redirect_pc;
  logic        b_dec_valid, b_dec_ready;
  logic [31:0] b_dec_instr;
  logic [7:0]  b_dec_pc;
  logic        b_fetch_halted;

  int          tests = 0;
  int          fails = 0;
  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_buffer u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_halted   (fetch_halted)
  );

  fetch_buffer #(.ADDR_WIDTH(8)) u_dut_w8 (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (b_imem_req),
    .imem_addr      (b_imem_addr),
    .imem_rdata     (b_imem_rdata),
    .redirect_valid (b_redirect_valid),
    .redirect_pc    (b_redirect_pc),
    .dec_valid      (b_dec_valid),
    .dec_ready      (b_dec_ready),
    .dec_instr      (b_dec_instr),
    .dec_pc         (b_dec_pc),
    .fetch_halted   (b_fetch_halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && a == halt_addr) return 32'h0;
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00A00113;
      default: return {a[23:0], 8'h13};
    endcase
  endfunction

  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);
  always @(posedge clk) if (b_imem_req) b_imem_rdata <= {16'h0, b_imem_addr, 8'h13};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous assert mid-cycle, check reset outputs, release after two edges.
  task automatic reset_dut();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst imem_req",     64'(imem_req),     64'h0);
    check("rst dec_valid",    64'(dec_valid),    64'h0);
    check("rst dec_instr",    64'(dec_instr),    64'h0);
    check("rst dec_pc",       64'(dec_pc),       64'h0);
    check("rst fetch_halted", 64'(fetch_halted), 64'h0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    dec_ready        = 1'b1;
    b_redirect_valid = 1'b0;
    b_redirect_pc    = 8'h0;
    b_dec_ready      = 1'b1;

    // Reset then streaming
    reset_dut();
    step();
    check("first req",  64'(imem_req),  64'h1);
    check("first addr", 64'(imem_addr), 64'h0);
    step();
    check("second addr",      64'(imem_addr), 64'h4);
    check("no early valid",   64'(dec_valid), 64'h0);
    step();
    check("stream valid0", 64'(dec_valid), 64'h1);
    check("stream pc0",    64'(dec_pc),    64'h0);
    check("stream instr0", 64'(dec_instr), 64'h00500093);
    step();
    check("stream pc4",    64'(dec_pc),    64'h4);
    check("stream instr4", 64'(dec_instr), 64'h00A00113);
    step();
    check("stream pc8",    64'(dec_pc),    64'h8);
    check("stream instr8", 64'(dec_instr), 64'h00000813);

    // Backpressure: four requests, then stall with a stable head
    dec_ready = 1'b0;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp req",  64'(imem_req),  64'h1);
      check("bp addr", 64'(imem_addr), 64'(i * 4));
    end
    step();
    check("bp req stops", 64'(imem_req), 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp req low",   64'(imem_req),  64'h0);
      check("bp head vld",  64'(dec_valid), 64'h1);
      check("bp head pc",   64'(dec_pc),    64'h0);
      check("bp head inst", 64'(dec_instr), 64'h00500093);
    end
    dec_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("drain valid", 64'(dec_valid), 64'h1);
      check("drain pc",    64'(dec_pc),    64'(i * 4));
      step();
    end

    // Redirect with three queued and one in flight
    dec_ready = 1'b0;
    reset_dut();
    repeat (5) step();
    check("pre-redir valid", 64'(dec_valid), 64'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    check("redir cycle req", 64'(imem_req), 64'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("redir flushed",  64'(dec_valid), 64'h0);
    check("redir req",      64'(imem_req),  64'h1);
    check("redir addr",     64'(imem_addr), 64'h100);
    dec_ready = 1'b1;
    step();
    check("stale killed",   64'(dec_valid), 64'h0);
    step();
    check("redir dec vld",  64'(dec_valid), 64'h1);
    check("redir dec pc",   64'(dec_pc),    64'h100);
    check("redir dec inst", 64'(dec_instr), 64'h00010013);
    step();
    check("redir dec pc2",  64'(dec_pc),    64'h104);

    // Halt on the zero word at 0x8
    halt_en   = 1'b1;
    halt_addr = 32'h8;
    reset_dut();
    repeat (3) step();
    check("halt pc0",     64'(dec_pc), 64'h0);
    step();
    check("halt pc4",     64'(dec_pc),       64'h4);
    check("halt not yet", 64'(fetch_halted), 64'h0);
    step();
    check("halted",       64'(fetch_halted), 64'h1);
    check("halt no 0x8",  64'(dec_valid),    64'h0);
    check("halt no req",  64'(imem_req),     64'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt hold req",   64'(imem_req),     64'h0);
      check("halt hold valid", 64'(dec_valid),    64'h0);
      check("halt hold flag",  64'(fetch_halted), 64'h1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    #1;
    check("halt redir req", 64'(imem_req), 64'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("resume flag", 64'(fetch_halted), 64'h0);
    check("resume req",  64'(imem_req),     64'h1);
    check("resume addr", 64'(imem_addr),    64'h20);
    step();
    step();
    check("resume valid", 64'(dec_valid), 64'h1);
    check("resume pc",    64'(dec_pc),    64'h20);
    check("run req high", 64'(imem_req),  64'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check("run redir req", 64'(imem_req), 64'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("run redir addr", 64'(imem_addr), 64'h40);

    // Reset mid-operation: two queued, one in flight
    dec_ready = 1'b0;
    repeat (3) step();
    check("mid valid", 64'(dec_valid), 64'h1);
    check("mid pc",    64'(dec_pc),    64'h40);
    halt_en   = 1'b0;
    dec_ready = 1'b1;
    reset_dut();
    step();
    check("restart addr",  64'(imem_addr), 64'h0);
    check("restart empty", 64'(dec_valid), 64'h0);
    step();
    check("restart empty2", 64'(dec_valid), 64'h0);
    step();
    check("restart valid", 64'(dec_valid), 64'h1);
    check("restart pc",    64'(dec_pc),    64'h0);

    // PC wrap on the 8-bit-address instance
    b_redirect_valid = 1'b1;
    b_redirect_pc    = 8'hFE;
    step();
    b_redirect_valid = 1'b0;
    #1;
    check("wrap req",  64'(b_imem_req),  64'h1);
    check("wrap addr", 64'(b_imem_addr), 64'hFC);
    step();
    check("wrap addr next", 64'(b_imem_addr), 64'h00);
    step();
    check("wrap dec vld",  64'(b_dec_valid), 64'h1);
    check("wrap dec pc",   64'(b_dec_pc),    64'hFC);
    check("wrap dec inst", 64'(b_dec_instr), 64'h0000FC13);
    step();
    check("wrap dec pc0",  64'(b_dec_pc),       64'h00);
    check("wrap no halt",  64'(b_fetch_halted), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
